rfd_lock_ctrl: RTL and testbench
================================

# rfd_lock_ctrl

Lock-acquisition controller for the rotational frequency detector, in the `clk_ref` domain. It drives the detector's reset and its `max_sample_count` / `max_rotation_shift` configuration. It walks a coarse-then-fine threshold schedule and qualifies the detector's per-window `error` with consecutive-window hysteresis. The result is a clean `locked` status and a `lock_lost` event for system firmware.

## Interface
- SAMPLE_CTR_SIZE, 14, width of the sample-count config; matches the detector.
- ROT_SH_CTR_SIZE, 5, rotation-shift counter size; shift config is ROT_SH_CTR_SIZE-1 bits.
- HYST_CNT_SIZE, 4, width of the window hysteresis counters.
- RST_CYCLES, 4, number of `clk_ref` cycles `rfd_rstn` is held low per reset pulse; must be ≥2.

Ports:
- clk_ref  in  1  single clock; all logic is rising-edge.
- rstn  in  1  asynchronous, active-low reset.
- enable  in  1  level; low forces IDLE.
- coarse_sample_count  in  SAMPLE_CTR_SIZE  window length, coarse profile.
- coarse_rotation_shift  in  ROT_SH_CTR_SIZE-1  allowed shift, coarse profile.
- fine_sample_count  in  SAMPLE_CTR_SIZE  window length, fine profile.
- fine_rotation_shift  in  ROT_SH_CTR_SIZE-1  allowed shift, fine profile.
- lock_windows  in  HYST_CNT_SIZE  consecutive good windows needed to advance; 0 is treated as 1.
- unlock_windows  in  HYST_CNT_SIZE  consecutive bad windows needed to fall back; 0 is treated as 1.
- rfd_sample  in  1  one-cycle pulse from the detector marking window end.
- rfd_error  in  1  detector error; sampled only when `rfd_sample`=1.
- rfd_rstn  out  1  registered reset to the detector.
- max_sample_count  out  SAMPLE_CTR_SIZE  registered config to the detector.
- max_rotation_shift  out  ROT_SH_CTR_SIZE-1  registered config to the detector.
- locked  out  1  lock status.
- lock_lost  out  1  one-cycle pulse when lock is lost.
- state  out  3  current state code.

## Operation
States and codes: IDLE=0, RST=1, COARSE=2, FINE=3, LOCKED=4. A `target` register records the state RST exits to.

- **IDLE:** `rfd_rstn`=0. When `enable`=1, go to RST with target=COARSE.
- **RST entry:** latch the target profile's count and shift into the `max_*` outputs. Config inputs are therefore sampled only here.
- **RST:** hold `rfd_rstn`=0 for RST_CYCLES cycles, then go to target. Set `skip`=1 so the first `rfd_sample` afterwards, a partial window, is ignored.
- **Window evaluation:** each `rfd_sample` with `skip`=0 is good if `rfd_error`=0, bad otherwise.
  - A good window increments `good_cnt` and clears `bad_cnt`.
  - A bad window increments `bad_cnt` and clears `good_cnt`.
  - Both counters saturate and are cleared on every RST entry.
- **COARSE:** when `good_cnt` reaches lock_windows, go to RST with target=FINE. Bad windows only clear `good_cnt`.
- **FINE:** when `good_cnt` reaches lock_windows, go to LOCKED. No detector reset occurs and the profile is unchanged. When `bad_cnt` reaches unlock_windows, go to RST with target=COARSE.
- **LOCKED:** `locked`=1. When `bad_cnt` reaches unlock_windows, pulse `lock_lost`, clear `locked`, and go to RST with target=COARSE.
- **enable=0 in any state:** go to IDLE next cycle. `locked` is cleared and there is no `lock_lost` pulse.

## Timing
- **Reset values:** state=IDLE, `rfd_rstn`=0, `max_sample_count`=0, `max_rotation_shift`=0, `locked`=0, `lock_lost`=0, `skip`=0, counters=0.
- **Start-up:** if `enable` rises in cycle t:
  - state=RST at t+1;
  - `rfd_rstn` is low t+1 .. t+RST_CYCLES;
  - state=COARSE with `rfd_rstn`=1 at t+RST_CYCLES+1.
- **Profile change:** the `max_*` outputs change in the first RST cycle, while `rfd_rstn` is already low.
- **Lock/unlock latency:** the state change, the rise of `locked`, and the `lock_lost` pulse/`locked` fall all occur in the cycle after the qualifying `rfd_sample`.
- **Precedence and boundary cases:**
  - `enable`=0 overrides a simultaneous `rfd_sample`.
  - `rfd_sample` is ignored in IDLE and RST.
  - A threshold reached and a threshold change on the same cycle uses the current input value, except in RST.
  - `rstn` asserted mid-sequence returns all outputs to reset values immediately.

## Structure
- Package `rfd_ctrl_pkg` holds the state encoding constants and the RST_CYCLES counter width function.
- One sub-module, `rfd_win_cnt`: a saturating HYST_CNT_SIZE counter with clear/inc inputs and a `reached` flag (count ≥ max(threshold,1)). It is instantiated twice, for good and bad windows.

## Test plan
- **Start-up:** `enable`=1 at cycle 10, RST_CYCLES=4.
  - `rfd_rstn` is low cycles 11–14 and state=COARSE at 15.
  - The `max_*` outputs equal the coarse config from cycle 11.
- **Lock path:** lock_windows=3, no errors.
  - The first pulse is skipped; 3 good pulses move COARSE→RST→FINE.
  - After RST, the skip plus 3 good pulses give LOCKED; `locked` rises the cycle after the 3rd pulse.
- **Hysteresis in LOCKED:** unlock_windows=2.
  - The pattern bad, good, bad keeps `locked`=1.
  - The pattern bad, bad gives a one-cycle `lock_lost`, `locked`=0, state=RST, then COARSE, and the `max_*` outputs return to coarse values.
- **Fine failure:** in FINE, 2 bad windows with unlock_windows=2 give RST→COARSE, with no `lock_lost` pulse.
- **Zero thresholds:** lock_windows=0 advances on the first good window.
- **Disable and reset:**
  - `enable`=0 in the same cycle as `rfd_sample` in LOCKED gives IDLE next cycle, `locked`=0, and no `lock_lost`.
  - `rstn` pulsed in FINE gives all outputs at reset values.

Source files
------------

// File: rtl/rfd_lock_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : rfd_ctrl_pkg
// Purpose  : State encoding and sizing helpers shared by the lock controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rfd_ctrl_pkg;

    // Width of the externally visible state code
    localparam int STATE_W = 3;

    // Controller states; the codes are visible on the state output
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RST    = 3'd1,
        ST_COARSE = 3'd2,
        ST_FINE   = 3'd3,
        ST_LOCKED = 3'd4
    } state_t;

    // Bits needed for a counter running 0 .. cycles-1 (never narrower than 1)
    function automatic int rst_cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rfd_lock_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : rfd_lock_ctrl_if
// Purpose  : Controller <-> rotational frequency detector signal bundle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface rfd_lock_ctrl_if #(
    parameter int SAMPLE_CTR_SIZE = 14,
    parameter int ROT_SH_CTR_SIZE = 5
);
    // Detector status towards the controller
    logic                         rfd_sample;
    logic                         rfd_error;
    // Controller reset and configuration towards the detector
    logic                         rfd_rstn;
    logic [SAMPLE_CTR_SIZE-1:0]   max_sample_count;
    logic [ROT_SH_CTR_SIZE-2:0]   max_rotation_shift;

    // Controller side
    modport master (
        input  rfd_sample,
        input  rfd_error,
        output rfd_rstn,
        output max_sample_count,
        output max_rotation_shift
    );

    // Detector side
    modport slave (
        output rfd_sample,
        output rfd_error,
        input  rfd_rstn,
        input  max_sample_count,
        input  max_rotation_shift
    );

endinterface

`default_nettype wire

// File: rtl/rfd_lock_ctrl_win_cnt.sv
//------------------------------------------------------------------------------
// Module   : rfd_win_cnt
// Purpose  : Saturating consecutive-window counter with threshold flag.
//            'reached' looks at the count as it will be after this cycle's
//            clear/inc, so the controller can act on the qualifying window
//            itself instead of one cycle later. A zero threshold acts as 1.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rfd_win_cnt #(
    parameter int HYST_CNT_SIZE = 4
) (
    input  wire logic                     clk_ref,
    input  wire logic                     rstn,
    input  wire logic                     clear,
    input  wire logic                     inc,
    input  wire logic [HYST_CNT_SIZE-1:0] threshold,
    output logic                          reached
);

    localparam logic [HYST_CNT_SIZE-1:0] CNT_MAX = '1;
    localparam logic [HYST_CNT_SIZE-1:0] CNT_ONE = HYST_CNT_SIZE'(1);

    logic [HYST_CNT_SIZE-1:0] count;
    logic [HYST_CNT_SIZE-1:0] count_nxt;
    logic [HYST_CNT_SIZE-1:0] thr_eff;

    // Next count: clear wins over increment, increment stops at all-ones
    always_comb begin
        count_nxt = count;
        if (clear) begin
            count_nxt = '0;
        end else if (inc && (count != CNT_MAX)) begin
            count_nxt = count + CNT_ONE;
        end
    end

    assign thr_eff = (threshold == '0) ? CNT_ONE : threshold;
    assign reached = (count_nxt >= thr_eff);

    // Count register
    always_ff @(posedge clk_ref or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/rfd_lock_ctrl.sv
//------------------------------------------------------------------------------
// Module   : rfd_lock_ctrl
// Purpose  : Lock-acquisition controller for the rotational frequency
//            detector. Walks a coarse-then-fine threshold profile, resets the
//            detector on every profile change and qualifies per-window errors
//            with consecutive-window hysteresis to produce locked/lock_lost.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rfd_lock_ctrl
    import rfd_ctrl_pkg::*;
#(
    parameter int SAMPLE_CTR_SIZE = 14,
    parameter int ROT_SH_CTR_SIZE = 5,
    parameter int HYST_CNT_SIZE   = 4,
    parameter int RST_CYCLES      = 4
) (
    input  wire logic                       clk_ref,
    input  wire logic                       rstn,
    input  wire logic                       enable,
    input  wire logic [SAMPLE_CTR_SIZE-1:0] coarse_sample_count,
    input  wire logic [ROT_SH_CTR_SIZE-2:0] coarse_rotation_shift,
    input  wire logic [SAMPLE_CTR_SIZE-1:0] fine_sample_count,
    input  wire logic [ROT_SH_CTR_SIZE-2:0] fine_rotation_shift,
    input  wire logic [HYST_CNT_SIZE-1:0]   lock_windows,
    input  wire logic [HYST_CNT_SIZE-1:0]   unlock_windows,
    output logic                            locked,
    output logic                            lock_lost,
    output logic [STATE_W-1:0]              state,
    rfd_lock_ctrl_if.master                 det
);

    localparam int                   RST_CNT_W = rst_cnt_width(RST_CYCLES);
    localparam logic [RST_CNT_W-1:0] RST_LAST  = RST_CNT_W'(RST_CYCLES - 1);
    localparam logic [RST_CNT_W-1:0] RST_ONE   = RST_CNT_W'(1);

    state_t                 cur_state;
    state_t                 target;
    logic [RST_CNT_W-1:0]   rst_cnt;
    logic                   skip;

    logic                   active;
    logic                   win_valid;
    logic                   win_good;
    logic                   win_bad;
    logic                   cnt_clear;
    logic                   good_reached;
    logic                   bad_reached;
    logic                   good_fire;
    logic                   bad_fire;
    logic                   rst_req;
    logic                   rst_to_fine;

    // Windows only count in the tracking states; the first one after a
    // detector reset is partial and is swallowed by 'skip'.
    assign active    = (cur_state == ST_COARSE) || (cur_state == ST_FINE) ||
                       (cur_state == ST_LOCKED);
    assign win_valid = enable && det.rfd_sample && active && !skip;
    assign win_good  = win_valid && !det.rfd_error;
    assign win_bad   = win_valid &&  det.rfd_error;

    // Counters sit at zero while idle or holding the detector in reset, so
    // every RST entry starts a fresh hysteresis run.
    assign cnt_clear = (cur_state == ST_IDLE) || (cur_state == ST_RST);

    rfd_win_cnt #(
        .HYST_CNT_SIZE (HYST_CNT_SIZE)
    ) u_good_cnt (
        .clk_ref   (clk_ref),
        .rstn      (rstn),
        .clear     (cnt_clear || win_bad),
        .inc       (win_good),
        .threshold (lock_windows),
        .reached   (good_reached)
    );

    rfd_win_cnt #(
        .HYST_CNT_SIZE (HYST_CNT_SIZE)
    ) u_bad_cnt (
        .clk_ref   (clk_ref),
        .rstn      (rstn),
        .clear     (cnt_clear || win_good),
        .inc       (win_bad),
        .threshold (unlock_windows),
        .reached   (bad_reached)
    );

    assign good_fire = win_good && good_reached;
    assign bad_fire  = win_bad  && bad_reached;

    // Decide whether this cycle enters RST and which profile it loads
    always_comb begin
        rst_req     = 1'b0;
        rst_to_fine = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                rst_req = 1'b1;
            end
            ST_COARSE: begin
                if (good_fire) begin
                    rst_req     = 1'b1;
                    rst_to_fine = 1'b1;
                end
            end
            ST_FINE, ST_LOCKED: begin
                rst_req = bad_fire;
            end
            default: begin
                rst_req = 1'b0;
            end
        endcase
    end

    // Main state machine with registered detector config and status outputs
    always_ff @(posedge clk_ref or negedge rstn) begin
        if (!rstn) begin
            cur_state              <= ST_IDLE;
            target                 <= ST_COARSE;
            rst_cnt                <= '0;
            skip                   <= 1'b0;
            locked                 <= 1'b0;
            lock_lost              <= 1'b0;
            det.rfd_rstn           <= 1'b0;
            det.max_sample_count   <= '0;
            det.max_rotation_shift <= '0;
        end else begin
            lock_lost <= 1'b0;
            if (!enable) begin
                // Disable is a quiet stop: no lock_lost event
                cur_state    <= ST_IDLE;
                locked       <= 1'b0;
                skip         <= 1'b0;
                det.rfd_rstn <= 1'b0;
            end else if (rst_req) begin
                // Config inputs are captured only here, so the detector sees
                // a new profile exactly while it is held in reset.
                cur_state    <= ST_RST;
                target       <= rst_to_fine ? ST_FINE : ST_COARSE;
                det.max_sample_count   <= rst_to_fine ? fine_sample_count
                                                      : coarse_sample_count;
                det.max_rotation_shift <= rst_to_fine ? fine_rotation_shift
                                                      : coarse_rotation_shift;
                det.rfd_rstn <= 1'b0;
                rst_cnt      <= '0;
                skip         <= 1'b1;
                locked       <= 1'b0;
                if (cur_state == ST_LOCKED) begin
                    lock_lost <= 1'b1;
                end
            end else begin
                if (det.rfd_sample && active) begin
                    skip <= 1'b0;
                end
                case (cur_state)
                    ST_RST: begin
                        if (rst_cnt == RST_LAST) begin
                            cur_state    <= target;
                            det.rfd_rstn <= 1'b1;
                        end else begin
                            rst_cnt <= rst_cnt + RST_ONE;
                        end
                    end
                    ST_FINE: begin
                        // Fine lock keeps the detector running on the same profile
                        if (good_fire) begin
                            cur_state <= ST_LOCKED;
                            locked    <= 1'b1;
                        end
                    end
                    default: begin
                        cur_state <= cur_state;
                    end
                endcase
            end
        end
    end

    assign state = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_rfd_lock_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_rfd_lock_ctrl
// Purpose  : Self-checking bench for rfd_lock_ctrl: directed scenarios plus a
//            randomized run against a behavioural model of the lock rules.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rfd_lock_ctrl;

    localparam int SCS  = 14;
    localparam int RSS  = 5;
    localparam int HCS  = 4;
    localparam int RSTC = 4;
    localparam int CMAX = (1 << HCS) - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RST    = 3'd1;
    localparam logic [2:0] S_COARSE = 3'd2;
    localparam logic [2:0] S_FINE   = 3'd3;
    localparam logic [2:0] S_LOCKED = 3'd4;

    logic           clk_ref = 1'b0;
    logic           rstn    = 1'b0;
    logic           enable  = 1'b0;
    logic [SCS-1:0] coarse_sample_count = '0;
    logic [RSS-2:0] coarse_rotation_shift = '0;
    logic [SCS-1:0] fine_sample_count = '0;
    logic [RSS-2:0] fine_rotation_shift = '0;
    logic [HCS-1:0] lock_windows = '0;
    logic [HCS-1:0] unlock_windows = '0;
    logic           locked;
    logic           lock_lost;
    logic [2:0]     state;

    rfd_lock_ctrl_if #(.SAMPLE_CTR_SIZE(SCS), .ROT_SH_CTR_SIZE(RSS)) det_if ();

    rfd_lock_ctrl #(
        .SAMPLE_CTR_SIZE (SCS),
        .ROT_SH_CTR_SIZE (RSS),
        .HYST_CNT_SIZE   (HCS),
        .RST_CYCLES      (RSTC)
    ) dut (
        .clk_ref               (clk_ref),
        .rstn                  (rstn),
        .enable                (enable),
        .coarse_sample_count   (coarse_sample_count),
        .coarse_rotation_shift (coarse_rotation_shift),
        .fine_sample_count     (fine_sample_count),
        .fine_rotation_shift   (fine_rotation_shift),
        .lock_windows          (lock_windows),
        .unlock_windows        (unlock_windows),
        .locked                (locked),
        .lock_lost             (lock_lost),
        .state                 (state),
        .det                   (det_if)
    );

    always #5 clk_ref = ~clk_ref;

    int checks = 0;
    int errors = 0;

    // Reference model: expected outputs plus the abstract lock bookkeeping
    logic [2:0]     m_state, m_target;
    logic           m_locked, m_lost, m_rfd_rstn;
    logic [SCS-1:0] m_msc;
    logic [RSS-2:0] m_mrs;
    int             m_rst_left, m_good, m_bad;
    bit             m_skip;

    task automatic model_reset();
        m_state = S_IDLE; m_target = S_COARSE; m_locked = 0; m_lost = 0;
        m_rfd_rstn = 0; m_msc = '0; m_mrs = '0; m_rst_left = 0;
        m_good = 0; m_bad = 0; m_skip = 0;
    endtask

    task automatic model_enter_rst(input logic [2:0] tgt);
        m_state    = S_RST;
        m_target   = tgt;
        m_msc      = (tgt == S_FINE) ? fine_sample_count : coarse_sample_count;
        m_mrs      = (tgt == S_FINE) ? fine_rotation_shift : coarse_rotation_shift;
        m_rfd_rstn = 0;
        m_rst_left = RSTC;
        m_skip     = 1;
        m_good     = 0;
        m_bad      = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_step();
        int lw, uw;
        if (!rstn) begin
            model_reset();
            return;
        end
        m_lost = 0;
        lw = (lock_windows == 0) ? 1 : int'(lock_windows);
        uw = (unlock_windows == 0) ? 1 : int'(unlock_windows);
        if (!enable) begin
            m_state = S_IDLE; m_locked = 0; m_skip = 0; m_rfd_rstn = 0;
            m_good = 0; m_bad = 0;
        end else if (m_state == S_IDLE) begin
            model_enter_rst(S_COARSE);
        end else if (m_state == S_RST) begin
            if (m_rst_left == 1) begin
                m_state = m_target;
                m_rfd_rstn = 1;
            end else begin
                m_rst_left--;
            end
        end else if (det_if.rfd_sample) begin
            if (m_skip) begin
                m_skip = 0;
            end else if (!det_if.rfd_error) begin
                m_good = (m_good < CMAX) ? m_good + 1 : CMAX;
                m_bad  = 0;
                if (m_good >= lw) begin
                    if (m_state == S_COARSE) begin
                        model_enter_rst(S_FINE);
                    end else if (m_state == S_FINE) begin
                        m_state = S_LOCKED;
                        m_locked = 1;
                    end
                end
            end else begin
                m_bad  = (m_bad < CMAX) ? m_bad + 1 : CMAX;
                m_good = 0;
                if (m_bad >= uw && m_state != S_COARSE) begin
                    if (m_state == S_LOCKED) begin
                        m_lost = 1;
                        m_locked = 0;
                    end
                    model_enter_rst(S_COARSE);
                end
            end
        end
    endtask

    // One clock: model consumes current inputs, DUT sampled 1ns after the edge
    task automatic cycle();
        model_step();
        @(posedge clk_ref);
        #1;
    endtask

    // Single-cycle detector window pulse
    task automatic pulse(input logic err);
        det_if.rfd_sample = 1'b1;
        det_if.rfd_error  = err;
        cycle();
        det_if.rfd_sample = 1'b0;
        det_if.rfd_error  = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int max_cyc);
        for (int i = 0; i < max_cyc && state !== s; i++) cycle();
    endtask

    task automatic test_reset();
        det_if.rfd_sample = 0; det_if.rfd_error = 0;
        rstn = 0; enable = 0;
        repeat (3) cycle();
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); end
        checks++; if (det_if.rfd_rstn !== 1'b0) begin errors++; $display("FAIL reset_rfd_rstn: got %0b want 0", det_if.rfd_rstn); end
        checks++; if (det_if.max_sample_count !== '0) begin errors++; $display("FAIL reset_msc: got %0h want 0", det_if.max_sample_count); end
        checks++; if (det_if.max_rotation_shift !== '0) begin errors++; $display("FAIL reset_mrs: got %0h want 0", det_if.max_rotation_shift); end
        checks++; if (locked !== 1'b0 || lock_lost !== 1'b0) begin errors++; $display("FAIL reset_status: got locked=%0b lost=%0b want 0 0", locked, lock_lost); end
        rstn = 1;
        repeat (2) cycle();
        checks++; if (state !== S_IDLE) begin errors++; $display("FAIL idle_hold: got %0d want %0d", state, S_IDLE); end
    endtask

    task automatic test_startup();
        coarse_sample_count   = 14'h1234;
        coarse_rotation_shift = 4'h5;
        fine_sample_count     = 14'h2abc;
        fine_rotation_shift   = 4'h2;
        enable = 1;
        for (int k = 1; k <= RSTC; k++) begin
            cycle();
            checks++; if (state !== S_RST || det_if.rfd_rstn !== 1'b0) begin errors++; $display("FAIL startup_rst k=%0d: got state=%0d rstn=%0b want 1 0", k, state, det_if.rfd_rstn); end
            checks++; if (det_if.max_sample_count !== 14'h1234 || det_if.max_rotation_shift !== 4'h5) begin errors++; $display("FAIL startup_cfg k=%0d: got %0h/%0h want 1234/5", k, det_if.max_sample_count, det_if.max_rotation_shift); end
        end
        cycle();
        checks++; if (state !== S_COARSE || det_if.rfd_rstn !== 1'b1) begin errors++; $display("FAIL startup_coarse: got state=%0d rstn=%0b want 2 1", state, det_if.rfd_rstn); end
    endtask

    task automatic test_lock_path();
        lock_windows = 3; unlock_windows = 2;
        pulse(0); cycle();
        pulse(0); cycle();
        pulse(0); cycle();
        checks++; if (state !== S_COARSE) begin errors++; $display("FAIL lock_skip_coarse: got %0d want %0d", state, S_COARSE); end
        pulse(0);
        checks++; if (state !== S_RST || det_if.rfd_rstn !== 1'b0) begin errors++; $display("FAIL lock_to_rst: got state=%0d rstn=%0b want 1 0", state, det_if.rfd_rstn); end
        checks++; if (det_if.max_sample_count !== 14'h2abc || det_if.max_rotation_shift !== 4'h2) begin errors++; $display("FAIL lock_fine_cfg: got %0h/%0h want 2abc/2", det_if.max_sample_count, det_if.max_rotation_shift); end
        wait_state(S_FINE, 10);
        checks++; if (state !== S_FINE || det_if.rfd_rstn !== 1'b1) begin errors++; $display("FAIL lock_fine: got state=%0d rstn=%0b want 3 1", state, det_if.rfd_rstn); end
        pulse(0); cycle();
        pulse(0); cycle();
        pulse(0);
        checks++; if (state !== S_FINE || locked !== 1'b0) begin errors++; $display("FAIL lock_fine_wait: got state=%0d locked=%0b want 3 0", state, locked); end
        cycle();
        pulse(0);
        checks++; if (state !== S_LOCKED || locked !== 1'b1) begin errors++; $display("FAIL lock_locked: got state=%0d locked=%0b want 4 1", state, locked); end
        cycle();
    endtask

    task automatic test_hysteresis();
        logic errs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        unlock_windows = 2;
        foreach (errs[i]) begin
            pulse(errs[i]);
            checks++; if (locked !== 1'b1 || lock_lost !== 1'b0 || state !== S_LOCKED) begin errors++; $display("FAIL hyst_hold %0d: got locked=%0b lost=%0b state=%0d want 1 0 4", i, locked, lock_lost, state); end
            cycle();
        end
        pulse(1);
        checks++; if (locked !== 1'b1 || lock_lost !== 1'b0) begin errors++; $display("FAIL hyst_first_bad: got locked=%0b lost=%0b want 1 0", locked, lock_lost); end
        cycle();
        pulse(1);
        checks++; if (lock_lost !== 1'b1 || locked !== 1'b0 || state !== S_RST) begin errors++; $display("FAIL hyst_lost: got lost=%0b locked=%0b state=%0d want 1 0 1", lock_lost, locked, state); end
        checks++; if (det_if.max_sample_count !== 14'h1234 || det_if.max_rotation_shift !== 4'h5) begin errors++; $display("FAIL hyst_coarse_cfg: got %0h/%0h want 1234/5", det_if.max_sample_count, det_if.max_rotation_shift); end
        cycle();
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL hyst_lost_width: got %0b want 0", lock_lost); end
        wait_state(S_COARSE, 10);
        checks++; if (state !== S_COARSE) begin errors++; $display("FAIL hyst_back_coarse: got %0d want %0d", state, S_COARSE); end
    endtask

    task automatic test_fine_failure();
        lock_windows = 1; unlock_windows = 2;
        pulse(0); cycle();
        pulse(0);
        checks++; if (state !== S_RST) begin errors++; $display("FAIL ff_to_rst: got %0d want %0d", state, S_RST); end
        wait_state(S_FINE, 10);
        pulse(1); cycle();
        pulse(1);
        checks++; if (state !== S_FINE) begin errors++; $display("FAIL ff_skip_err: got %0d want %0d", state, S_FINE); end
        cycle();
        pulse(1);
        checks++; if (state !== S_RST || lock_lost !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL ff_fall: got state=%0d lost=%0b locked=%0b want 1 0 0", state, lock_lost, locked); end
        wait_state(S_COARSE, 10);
        checks++; if (state !== S_COARSE || det_if.max_sample_count !== 14'h1234) begin errors++; $display("FAIL ff_coarse: got state=%0d msc=%0h want 2 1234", state, det_if.max_sample_count); end
    endtask

    task automatic test_zero_thresholds();
        lock_windows = 0;
        pulse(0); cycle();
        pulse(0);
        checks++; if (state !== S_RST) begin errors++; $display("FAIL zero_coarse: got %0d want %0d", state, S_RST); end
        wait_state(S_FINE, 10);
        pulse(0); cycle();
        pulse(0);
        checks++; if (state !== S_LOCKED || locked !== 1'b1) begin errors++; $display("FAIL zero_fine: got state=%0d locked=%0b want 4 1", state, locked); end
        cycle();
    endtask

    task automatic test_disable();
        unlock_windows = 1;
        enable = 0;
        pulse(1);
        checks++; if (state !== S_IDLE || locked !== 1'b0 || lock_lost !== 1'b0 || det_if.rfd_rstn !== 1'b0) begin errors++; $display("FAIL disable: got state=%0d locked=%0b lost=%0b rstn=%0b want 0 0 0 0", state, locked, lock_lost, det_if.rfd_rstn); end
        cycle();
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL disable_nolost: got %0b want 0", lock_lost); end
        enable = 1;
        cycle();
        checks++; if (state !== S_RST) begin errors++; $display("FAIL reenable: got %0d want %0d", state, S_RST); end
    endtask

    task automatic test_async_reset();
        lock_windows = 1;
        wait_state(S_COARSE, 10);
        pulse(0); cycle();
        pulse(0);
        wait_state(S_FINE, 10);
        checks++; if (state !== S_FINE) begin errors++; $display("FAIL ar_fine: got %0d want %0d", state, S_FINE); end
        #2 rstn = 0;
        #1;
        checks++; if (state !== S_IDLE || det_if.rfd_rstn !== 1'b0 || locked !== 1'b0 || lock_lost !== 1'b0) begin errors++; $display("FAIL ar_status: got state=%0d rstn=%0b locked=%0b lost=%0b want 0 0 0 0", state, det_if.rfd_rstn, locked, lock_lost); end
        checks++; if (det_if.max_sample_count !== '0 || det_if.max_rotation_shift !== '0) begin errors++; $display("FAIL ar_cfg: got %0h/%0h want 0/0", det_if.max_sample_count, det_if.max_rotation_shift); end
        model_reset();
        #2 rstn = 1;
        cycle();
    endtask

    task automatic test_random();
        int lost_seen = 0, lock_seen = 0;
        for (int n = 0; n < 4000; n++) begin
            det_if.rfd_sample = ($urandom_range(0, 2) == 0);
            det_if.rfd_error  = ($urandom_range(0, 4) == 0);
            enable = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 49) == 0) begin
                lock_windows   = HCS'($urandom_range(0, 3));
                unlock_windows = HCS'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 29) == 0) begin
                coarse_sample_count   = SCS'($urandom);
                coarse_rotation_shift = (RSS-1)'($urandom);
                fine_sample_count     = SCS'($urandom);
                fine_rotation_shift   = (RSS-1)'($urandom);
            end
            cycle();
            if (m_lost) lost_seen++;
            if (m_state == S_LOCKED) lock_seen++;
            checks++; if (state !== m_state) begin errors++; if (errors < 20) $display("FAIL rnd_state n=%0d: got %0d want %0d", n, state, m_state); end
            checks++; if (det_if.rfd_rstn !== m_rfd_rstn) begin errors++; if (errors < 20) $display("FAIL rnd_rstn n=%0d: got %0b want %0b", n, det_if.rfd_rstn, m_rfd_rstn); end
            checks++; if (det_if.max_sample_count !== m_msc || det_if.max_rotation_shift !== m_mrs) begin errors++; if (errors < 20) $display("FAIL rnd_cfg n=%0d: got %0h/%0h want %0h/%0h", n, det_if.max_sample_count, det_if.max_rotation_shift, m_msc, m_mrs); end
            checks++; if (locked !== m_locked || lock_lost !== m_lost) begin errors++; if (errors < 20) $display("FAIL rnd_status n=%0d: got %0b/%0b want %0b/%0b", n, locked, lock_lost, m_locked, m_lost); end
        end
        det_if.rfd_sample = 0;
        det_if.rfd_error  = 0;
        $display("random run: %0d lock-lost events, %0d locked cycles", lost_seen, lock_seen);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_startup();
        test_lock_path();
        test_hysteresis();
        test_fine_failure();
        test_zero_thresholds();
        test_disable();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
